// File: rtl/prefetch_unit_if.sv
// Pipelined Avalon-MM read bus used by the instruction fetch path.
// Host drives the command; Agent returns data in order via readdatavalid.
interface AvalonMmRead;
  logic [31:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] agent_to_host;

  modport Host  (output address, read, byteenable,
                 input  waitrequest, readdatavalid, agent_to_host);
  modport Agent (input  address, read, byteenable,
                 output waitrequest, readdatavalid, agent_to_host);
endinterface

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: keeps a small queue of fetched words ahead of the consumer,
// restarts on redirect and silently drains responses belonging to the abandoned stream.
module prefetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  AvalonMmRead.Host              instruction_manager,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_L = DEPTH[CW:0];
  localparam logic [CW-1:0] FULL_L  = DEPTH[CW-1:0];
  localparam logic [CW-1:0] MAX_L   = MAX_OUTSTANDING[CW-1:0];

  logic [31:0]   fetch_pc, resp_pc, hold_addr;
  logic          held, stale;
  logic [CW-1:0] outstanding, outstanding_nxt, discard, count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW:0]   inflight;
  logic          can_issue, accept, rsp, drop, push, pop;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  // Issue control: queue space is reserved for every read in flight
  assign inflight  = {1'b0, count} + {1'b0, outstanding};
  assign can_issue = (inflight < DEPTH_L) && (outstanding < MAX_L);

  assign instruction_manager.read       = rst && (held || can_issue);
  assign instruction_manager.address    = !rst ? 32'h0 : (held ? hold_addr : fetch_pc);
  assign instruction_manager.byteenable = 4'b1111;

  assign accept = instruction_manager.read && !instruction_manager.waitrequest;
  assign rsp    = instruction_manager.readdatavalid;
  assign drop   = rsp && (discard != '0);
  assign push   = rsp && !drop && !redirect;
  assign pop    = out_valid && out_ready && !redirect;

  assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      held        <= 1'b0;
      stale       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      held        <= instruction_manager.read && instruction_manager.waitrequest;
      // A command stalled across a redirect still belongs to the old stream
      if (accept)
        stale <= 1'b0;
      else if (redirect && instruction_manager.read)
        stale <= 1'b1;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        resp_pc  <= {redirect_pc[31:2], 2'b00};
        discard  <= outstanding_nxt;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept && !stale) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        discard <= discard - CW'(drop) + CW'(accept && stale);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Held address and queue storage: data only, no reset needed
  always_ff @(posedge clk) begin
    hold_addr <= instruction_manager.address;
    if (push) begin
      instr_q[wr_ptr] <= instruction_manager.agent_to_host;
      pc_q[wr_ptr]    <= resp_pc;
    end
  end

  assign occupancy = count;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? instr_q[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : 32'h0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count == FULL_L));
endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered bus reads (1..DEPTH).
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port instruction_manager, AvalonMmRead.Host, word, pipelined instruction read bus (address, read, byteenable, waitrequest, readdatavalid, agent_to_host).
REQ-007 The block SHALL have port redirect, input, 1, one-cycle request to restart fetch at redirect_pc.
REQ-008 The block SHALL have port redirect_pc, input, 32, new fetch address; bits [1:0] ignored (treated as 0).
REQ-009 The block SHALL have port out_valid, output, 1, queue head holds an instruction.
REQ-010 The block SHALL have port out_ready, input, 1, consumer takes head this cycle.
REQ-011 The block SHALL have port out_instr, output, 32, head instruction word.
REQ-012 The block SHALL have port out_pc, output, 32, address the head instruction was fetched from.
REQ-013 The block SHALL have port occupancy, output, $clog2(DEPTH)+1, valid queue entries.

Function
REQ-014 byteenable SHALL be constant 4'b1111.
REQ-015 read SHALL assert when occupancy + outstanding < DEPTH and outstanding < MAX_OUTSTANDING, or when a command is held.
REQ-016 Command accepted when read && !waitrequest; then fetch_pc += 4 (mod 2^32, wraps FFFF_FFFC -> 0) and outstanding += 1.
REQ-017 While read && waitrequest, address and read SHALL hold unchanged until acceptance (command held).
REQ-018 On readdatavalid: if discard > 0, discard -= 1 and data dropped; else push {agent_to_host, resp_pc}, resp_pc += 4; in both cases outstanding -= 1.
REQ-019 Acceptance and response in the same cycle SHALL leave outstanding unchanged.
REQ-020 Queue SHALL never overflow: space is reserved at issue per REQ-015; a push into a full queue is an error (assertion).
REQ-021 out_valid = (occupancy != 0); out_instr/out_pc are the head entry, combinational from queue state.
REQ-022 Pop on out_valid && out_ready; push and pop in the same cycle keep occupancy unchanged; pop on empty has no effect.
REQ-023 First instruction available: response in cycle N -> out_valid=1 in cycle N+1 (one registered stage, no bypass).
REQ-024 Redirect (cycle N): at N+1 queue empty, out_valid=0, fetch_pc=resp_pc=redirect_pc, discard = outstanding after cycle-N accounting (REQ-018/019).
REQ-025 Redirect while a command is held: command keeps old address until accepted, then discard += 1 and outstanding += 1; fetch_pc not incremented for it; new-address issue starts the cycle after.
REQ-026 Redirect with simultaneous pop or response: redirect wins; popped/pushed data is lost, responses still counted per REQ-018.
REQ-027 Back-to-back redirects: latest redirect_pc wins; discard accumulates all prior in-flight reads.
REQ-028 No issue is suppressed by discard > 0; new reads may issue while stale responses drain (in-order bus assumed).

Reset
REQ-029 rst=0 SHALL immediately force: read=0, address=0, fetch_pc=resp_pc=RESET_PC, occupancy=0, out_valid=0, out_instr=0, out_pc=0, outstanding=0, discard=0.
REQ-030 Reset mid-transaction SHALL abandon all in-flight reads; responses arriving after release are not expected (bus reset together).
REQ-031 First read SHALL assert in the first clock after rst deasserts, address RESET_PC.

Verification
REQ-032 Reset, zero-wait memory, out_ready=1, RESET_PC=0 -> addresses 0,4,8,...; out_pc 0,4,8 in order, out_instr matches memory, no gaps after first.
REQ-033 out_ready=0, DEPTH=4 -> exactly 4 reads issued, occupancy=4, read stays 0; set out_ready=1 -> reads resume, no data lost.
REQ-034 waitrequest=1 for 3 cycles on address 0x10 -> address stays 0x10 for 4 cycles, single acceptance, single entry pc 0x10.
REQ-035 Two reads outstanding (0x8,0xC), redirect to 0x100 -> both responses dropped, next out_pc=0x100, occupancy never exceeds DEPTH.
REQ-036 Redirect to 0x203 while command at 0x20 held -> 0x20 completes and is dropped; next address and out_pc 0x200.
REQ-037 redirect_pc=FFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
